// File: rtl/prio_enc_pkg.sv
// -----------------------------------------------------------------------------
// prio_enc_pkg
//   Shared definitions for the registered priority encoder / arbiter.
//   - PRIO_ENC_MAX_N : largest supported request vector width.
//   - arb_state_e    : output register state (IDLE = no result, HOLD = result
//                      waiting for the consumer).
//   - calc_w()       : index width rule, W = (N > 1) ? $clog2(N) : 1.
//   - onehot()       : converts an index into a one-hot vector of PRIO_ENC_MAX_N
//                      bits; callers keep the low N bits.
// -----------------------------------------------------------------------------
package prio_enc_pkg;

    localparam int PRIO_ENC_MAX_N = 256;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    function automatic int calc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits at or above n stay zero, so an out-of-range index yields all-zero.
    function automatic logic [PRIO_ENC_MAX_N-1:0] onehot(input int idx, input int n);
        logic [PRIO_ENC_MAX_N-1:0] oh;
        oh = '0;
        for (int i = 0; i < PRIO_ENC_MAX_N; i++) begin
            oh[i] = (i == idx) && (i < n);
        end
        return oh;
    endfunction

endpackage

// File: rtl/prio_enc_search.sv
// -----------------------------------------------------------------------------
// prio_enc_search
//   Combinational N-bit priority search. The search starts at position
//   start_i and descends, wrapping from 0 back to N-1; the first set request
//   bit encountered wins.
//
//   Parameters : N (request lines), W (index width, derived from N)
//   Ports      : req_i   [N-1:0]  request vector
//                start_i [W-1:0]  highest-priority position (must be < N)
//                found_o          at least one request bit is set
//                index_o [W-1:0]  winning position, 0 when nothing is set
// -----------------------------------------------------------------------------
module prio_enc_search
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = calc_w(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic         found_o,
    output logic [W-1:0] index_o
);

    // Position visited at search step k: (start - k) mod N.
    function automatic logic [W-1:0] wrap_pos(input logic [W-1:0] s, input int k);
        int p;
        p = int'(s) - k;
        if (p < 0) begin
            p = p + N;
        end
        return W'(p);
    endfunction

    logic [W-1:0] pos_reg [N];   // position examined at each search step
    logic [N-1:0] rot_req;       // requests reordered into search order

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign pos_reg[gi] = wrap_pos(start_i, gi);
        assign rot_req[gi] = req_i[pos_reg[gi]];
    end

    // Walk from the last search step down to the first so that the earliest
    // step with a set request is the final assignment and therefore wins.
    always_comb begin
        index_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                index_o = pos_reg[k];
            end
        end
    end

    assign found_o = |req_i;

endmodule

// File: rtl/prio_enc_arb.sv
// -----------------------------------------------------------------------------
// prio_enc_arb
//   Registered priority encoder with a valid/ready output handshake. Each
//   result (index, one-hot grant, valid) is held until the consumer accepts
//   it; a new result may load in the same cycle as the acceptance, allowing a
//   grant every cycle.
//
//   Build option: define PRIO_ENC_ARB_RR_EN to compile in round-robin mode.
//   Without it, the highest-numbered requesting line always wins.
//
//   Parameters : N (request lines, 2..256), W (index width, derived)
//   Ports      : clk            rising-edge clock
//                rst_n          synchronous active-low reset
//                req   [N-1:0]  request vector
//                ready          consumer accepts the current result
//                idx   [W-1:0]  index of the granted line
//                grant [N-1:0]  one-hot of idx while valid, else zero
//                valid          idx/grant carry a live result
// -----------------------------------------------------------------------------
module prio_enc_arb
    import prio_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = calc_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic [W-1:0] idx,
    output logic [N-1:0] grant,
    output logic         valid
);

    arb_state_e state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] grant_q, grant_d;

    logic         load;
    logic         found;
    logic [W-1:0] win;
    logic [W-1:0] start;
    logic [PRIO_ENC_MAX_N-1:0] oh_full;

    assign valid = (state_q == ST_HOLD);
    assign idx   = idx_q;
    assign grant = grant_q;

    // The output registers accept a new result whenever they are empty or
    // the current one is being consumed.
    assign load = !valid || ready;

`ifdef PRIO_ENC_ARB_RR_EN
    logic         handshake;
    logic [W-1:0] ptr_q, ptr_d;

    assign handshake = valid && ready;

    // After granting k, priority moves to the line just below k.
    always_comb begin
        ptr_d = ptr_q;
        if (handshake) begin
            ptr_d = (idx_q == '0) ? W'(N - 1) : idx_q - 1'b1;
        end
    end

    // The search uses the already-advanced pointer so that a result loading
    // in the same cycle as an acceptance sees the rotated priority; otherwise
    // back-to-back grants would repeat the previous winner.
    assign start = ptr_d;
`else
    assign start = W'(N - 1);
`endif

    prio_enc_search #(
        .N (N),
        .W (W)
    ) u_search (
        .req_i   (req),
        .start_i (start),
        .found_o (found),
        .index_o (win)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        oh_full = onehot(int'(win), N);
        if (load) begin
            if (found) begin
                state_d = ST_HOLD;
                idx_d   = win;
                grant_d = oh_full[N-1:0];
            end else begin
                state_d = ST_IDLE;
                idx_d   = '0;
                grant_d = '0;
            end
        end
    end

    // Upper one-hot bits are zero by construction and intentionally dropped.
    if (N < PRIO_ENC_MAX_N) begin : g_oh_unused
        logic unused_oh;
        assign unused_oh = ^oh_full[PRIO_ENC_MAX_N-1:N];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            grant_q <= '0;
`ifdef PRIO_ENC_ARB_RR_EN
            ptr_q   <= W'(N - 1);
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
`ifdef PRIO_ENC_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_prio_enc_arb.sv
// -----------------------------------------------------------------------------
// tb_prio_enc_arb
//   Directed, table-driven bench for prio_enc_arb. The N=8 instance is driven
//   from a vector table (fixed-priority or round-robin expectations depending
//   on PRIO_ENC_ARB_RR_EN); N=3 and N=2 instances cover narrow index widths.
// -----------------------------------------------------------------------------
module tb_prio_enc_arb;

    logic       clk;
    logic       rst_n;
    logic       ready;

    logic [7:0] req8;
    logic [2:0] idx8;
    logic [7:0] grant8;
    logic       valid8;

    logic [2:0] req3;
    logic [1:0] idx3;
    logic [2:0] grant3;
    logic       valid3;

    logic [1:0] req2;
    logic [0:0] idx2;
    logic [1:0] grant2;
    logic       valid2;

    int checks = 0;
    int errors = 0;

    prio_enc_arb #(.N(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req8),
        .ready (ready),
        .idx   (idx8),
        .grant (grant8),
        .valid (valid8)
    );

    prio_enc_arb #(.N(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req3),
        .ready (ready),
        .idx   (idx3),
        .grant (grant3),
        .valid (valid3)
    );

    prio_enc_arb #(.N(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req2),
        .ready (ready),
        .idx   (idx2),
        .grant (grant2),
        .valid (valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_idx;
        logic [7:0] exp_grant;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [7:0] q, input logic rd,
                                input logic v, input logic [2:0] i, input logic [7:0] g);
        vec_t e;
        e.rst_n     = r;
        e.req       = q;
        e.ready     = rd;
        e.exp_valid = v;
        e.exp_idx   = i;
        e.exp_grant = g;
        vecs.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ready = 1'b0;
        req8  = '0;
        req3  = '0;
        req2  = '0;

`ifdef PRIO_ENC_ARB_RR_EN
        add(0, 8'h00, 0, 0, 0, 8'h00);                 // reset
        for (int k = 0; k < 3; k++) add(1, 8'h00, 1, 0, 0, 8'h00);
        add(1, 8'h81, 1, 1, 7, 8'h80);                 // rotate 7,0,7,0
        add(1, 8'h81, 1, 1, 0, 8'h01);
        add(1, 8'h81, 1, 1, 7, 8'h80);
        add(1, 8'h81, 1, 1, 0, 8'h01);
        for (int k = 7; k >= 0; k--) add(1, 8'hFF, 1, 1, 3'(k), 8'(1 << k));
        add(1, 8'hFF, 1, 1, 7, 8'h80);                 // wraps back to 7
        add(1, 8'h00, 1, 0, 0, 8'h00);                 // ptr now 6
        add(1, 8'h04, 0, 1, 2, 8'h04);                 // search from 6 finds 2
        add(1, 8'h80, 0, 1, 2, 8'h04);                 // hold
        add(1, 8'h80, 0, 1, 2, 8'h04);
        add(1, 8'h80, 1, 1, 7, 8'h80);                 // accept 2 -> ptr 1 -> wraps to 7
        add(1, 8'h00, 1, 0, 0, 8'h00);                 // ptr now 6
        add(1, 8'h20, 0, 1, 5, 8'h20);
        add(0, 8'h20, 0, 0, 0, 8'h00);                 // reset mid-hold
        add(1, 8'hFF, 1, 1, 7, 8'h80);                 // ptr back at 7
        add(1, 8'h00, 1, 0, 0, 8'h00);                 // ptr now 6
        add(1, 8'h81, 1, 1, 0, 8'h01);                 // from 6 descends to 0
        add(1, 8'h81, 1, 1, 7, 8'h80);
        add(1, 8'h00, 1, 0, 0, 8'h00);
`else
        add(0, 8'h00, 0, 0, 0, 8'h00);                 // reset
        for (int k = 0; k < 5; k++) add(1, 8'h00, 1, 0, 0, 8'h00);
        add(1, 8'h81, 1, 1, 7, 8'h80);
        add(1, 8'h01, 1, 1, 0, 8'h01);
        add(1, 8'h00, 1, 0, 0, 8'h00);
        add(1, 8'h04, 0, 1, 2, 8'h04);                 // load while idle
        for (int k = 0; k < 3; k++) add(1, 8'h80, 0, 1, 2, 8'h04);
        add(1, 8'h80, 1, 1, 7, 8'h80);                 // accept + reload same edge
        add(1, 8'h00, 1, 0, 0, 8'h00);
        add(1, 8'h20, 0, 1, 5, 8'h20);
        add(0, 8'h20, 0, 0, 0, 8'h00);                 // reset mid-hold
        add(1, 8'h00, 0, 0, 0, 8'h00);
        add(1, 8'h02, 0, 1, 1, 8'h02);
        add(1, 8'h00, 0, 1, 1, 8'h02);                 // held line drops, still held
        add(1, 8'h00, 1, 0, 0, 8'h00);
        add(1, 8'hFF, 1, 1, 7, 8'h80);
        add(1, 8'hFF, 1, 1, 7, 8'h80);                 // fixed priority repeats
        add(1, 8'h5A, 1, 1, 6, 8'h40);
        add(1, 8'h00, 1, 0, 0, 8'h00);
`endif

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            rst_n = vecs[n].rst_n;
            req8  = vecs[n].req;
            ready = vecs[n].ready;
            @(posedge clk);
            #1;
            $display("vec %0d: rst_n=%b req=%h ready=%b -> valid=%b idx=%0d grant=%h",
                     n, vecs[n].rst_n, vecs[n].req, vecs[n].ready, valid8, idx8, grant8);
            chk($sformatf("vec%0d valid", n), 32'(valid8), 32'(vecs[n].exp_valid));
            chk($sformatf("vec%0d idx", n),   32'(idx8),   32'(vecs[n].exp_idx));
            chk($sformatf("vec%0d grant", n), 32'(grant8), 32'(vecs[n].exp_grant));
        end

        // Narrow widths: N=3 (W=2) and N=2 (W=1)
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        req8  = '0;
        req3  = 3'b011;
        req2  = 2'b10;
        @(posedge clk);
        #1;
        $display("narrow 1: req3=%b req2=%b -> idx3=%0d grant3=%b idx2=%0d grant2=%b",
                 req3, req2, idx3, grant3, idx2, grant2);
        chk("n3 valid", 32'(valid3), 32'd1);
        chk("n3 idx",   32'(idx3),   32'd1);
        chk("n3 grant", 32'(grant3), 32'b010);
        chk("n2 valid", 32'(valid2), 32'd1);
        chk("n2 idx",   32'(idx2),   32'd1);
        chk("n2 grant", 32'(grant2), 32'b10);

        @(negedge clk);
        req3 = 3'b100;
        req2 = 2'b11;
        @(posedge clk);
        #1;
        $display("narrow 2: req3=%b req2=%b -> idx3=%0d grant3=%b idx2=%0d grant2=%b",
                 req3, req2, idx3, grant3, idx2, grant2);
        chk("n3 idx top",   32'(idx3),   32'd2);
        chk("n3 grant top", 32'(grant3), 32'b100);
`ifdef PRIO_ENC_ARB_RR_EN
        chk("n2 idx rr",    32'(idx2),   32'd0);
        chk("n2 grant rr",  32'(grant2), 32'b01);
`else
        chk("n2 idx fix",   32'(idx2),   32'd1);
        chk("n2 grant fix", 32'(grant2), 32'b10);
`endif

        @(negedge clk);
        req3 = '0;
        req2 = '0;
        @(posedge clk);
        #1;
        $display("narrow 3: idle -> valid3=%b idx3=%0d valid2=%b grant2=%b",
                 valid3, idx3, valid2, grant2);
        chk("n3 idle valid", 32'(valid3), 32'd0);
        chk("n3 idle idx",   32'(idx3),   32'd0);
        chk("n2 idle valid", 32'(valid2), 32'd0);
        chk("n2 idle grant", 32'(grant2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
